wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have CLK  input  1  clock; all state updates on its rising edge.
REQ-002 SHALL have RST  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have in_valid  input  1  EX result valid; in_ready  output  1  stage can accept.
REQ-004 SHALL have Ins  input  32  instruction; Alu  input  32  ALU result or memory address; NextPC  input  32  PC+4; Sdata  input  32  store data (register-file port 2).
REQ-005 SHALL have dm_req  output  1; dm_we  output  1; dm_addr  output  32; dm_wdata  output  32; dm_ack  input  1; dm_rdata  input  32  data-memory port.
REQ-006 SHALL have rf_we  output  1; rf_waddr  output  5; rf_wdata  output  32  register-file write port, consumed by the decode stage on CLK.
REQ-007 SHALL have busy  output  1  high whenever the state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, MEM, WB.
REQ-009 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-010 In IDLE with in_valid=1, SHALL register Ins, Alu, NextPC, Sdata; next state MEM for LW/SW, WB for writing ops, IDLE otherwise.
REQ-011 Writing ops: R_FORM except funct JR (0x08); JAL; ADDI, ADDIU, SLTI, ANDI, ORI, XORI, LUI; LW. SW, BEQ, BNE, J and unknown opcodes SHALL write nothing.
REQ-012 In MEM, dm_req SHALL be 1 with dm_addr=Alu, dm_we=1 for SW else 0, dm_wdata=Sdata, all held stable until the cycle dm_ack=1.
REQ-013 On dm_ack in MEM: LW SHALL capture dm_rdata and go to WB; SW SHALL go to IDLE.
REQ-014 dm_ack SHALL be ignored outside MEM; dm_ack in the first MEM cycle is legal.
REQ-015 In WB, rf_we SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-016 rf_waddr SHALL be 31 for JAL, rd (Ins[15:11]) for R_FORM, rt (Ins[20:16]) otherwise.
REQ-017 rf_wdata SHALL be NextPC for JAL and for R_FORM funct JALR (0x09), captured load data for LW, Alu otherwise.
REQ-018 When rf_waddr=0, rf_we SHALL be forced to 0; FSM timing is unchanged.
REQ-019 Latency: non-memory op accepted at edge N SHALL present rf_we=1 during cycle N+1; LW acked at edge M SHALL present rf_we during cycle M+1.
REQ-020 rf_we, rf_waddr and rf_wdata SHALL come from registers, not from inputs combinationally.

Reset
REQ-021 RST SHALL set state to IDLE and in_ready=1; dm_req, dm_we, rf_we and busy to 0; all data registers and data outputs to 0.
REQ-022 RST asserted mid-MEM SHALL drop dm_req immediately and discard the operation; no register write SHALL follow.

Structure
REQ-023 Opcode/funct constants (R_FORM, JAL, LW, SW, BEQ, BNE, J, ADDI..LUI, JR, JALR) and FSM state encodings SHALL live in the shared common parameter package, which is also used by decode.
REQ-024 Destination-select and data-select logic SHALL be one sub-module, wb_sel (combinational, Ins/NextPC/Alu/load data in; waddr/wdata/write-enable out).

Verification
REQ-025 ADD $t1,$t2,$t3 (Alu=0x11) accepted -> next cycle rf_we=1, rf_waddr=9, rf_wdata=0x11; then idle.
REQ-026 LW $t0,4($s7) Alu=0x1B, dm_ack after 3 MEM cycles, dm_rdata=0xDEADBEEF -> dm_req high 3 cycles, dm_we=0, addr 0x1B; then rf_we, waddr=8, wdata=0xDEADBEEF.
REQ-027 SW Alu=0x20 Sdata=0x55 with same-cycle dm_ack -> dm_req one cycle, dm_we=1, wdata 0x55; no rf_we; in_ready back next cycle.
REQ-028 JAL NextPC=0x404 -> rf_waddr=31, rf_wdata=0x404; JALR rd=5 NextPC=0x108 -> waddr=5, wdata=0x108; BEQ -> no rf_we, in_ready stays 1.
REQ-029 ADDI with rt=0 -> rf_we stays 0; in_valid pulsed during MEM -> ignored, no extra write.
REQ-030 RST asserted during MEM wait -> dm_req=0 same cycle, state IDLE, late dm_ack ignored, no rf_we.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared opcode/funct constants and writeback FSM encoding, used by decode and writeback.
package wb_stage_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  localparam logic [4:0] RA_REG    = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } wb_state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/wb_stage_sel.sv
// Destination/data selection for the register-file write: pure combinational decode of one instruction.
module wb_sel
  import wb_stage_pkg::*;
(
  input  logic [31:0] ins_i,
  input  logic [31:0] next_pc_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] ld_data_i,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        we_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [9:0] unused_ins;

  assign op         = ins_i[31:26];
  assign funct      = ins_i[5:0];
  assign unused_ins = {ins_i[25:21], ins_i[10:6]};

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    we_o    = 1'b0;
    waddr_o = ins_i[20:16];
    wdata_o = alu_i;
    unique case (op)
      OP_R_FORM: begin
        we_o    = (funct != FN_JR);
        waddr_o = ins_i[15:11];
        if (funct == FN_JALR) wdata_o = next_pc_i;
      end
      OP_JAL: begin
        we_o    = 1'b1;
        waddr_o = RA_REG;
        wdata_o = next_pc_i;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: we_o = 1'b1;
      OP_LW: begin
        we_o    = 1'b1;
        wdata_o = ld_data_i;
      end
      default: we_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Memory/writeback stage: accepts one EX result, performs an optional data-memory access,
// then issues a single registered register-file write.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Ins,
  input  logic [31:0] Alu,
  input  logic [31:0] NextPC,
  input  logic [31:0] Sdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy
);

  wb_state_t   state_q, state_d;
  logic [31:0] ins_q, alu_q, npc_q, sdata_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  logic        accept;
  logic [31:0] sel_ins, sel_alu, sel_npc;
  logic [4:0]  sel_waddr;
  logic [31:0] sel_wdata;
  logic        sel_we;

  assign accept = (state_q == S_IDLE) && in_valid;

  // In IDLE the live inputs are decoded so a non-memory op can write on the very next cycle.
  assign sel_ins = (state_q == S_IDLE) ? Ins    : ins_q;
  assign sel_alu = (state_q == S_IDLE) ? Alu    : alu_q;
  assign sel_npc = (state_q == S_IDLE) ? NextPC : npc_q;

  wb_sel u_sel (
    .ins_i     (sel_ins),
    .next_pc_i (sel_npc),
    .alu_i     (sel_alu),
    .ld_data_i (dm_rdata),
    .waddr_o   (sel_waddr),
    .wdata_o   (sel_wdata),
    .we_o      (sel_we)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        if (is_mem_op(Ins[31:26])) state_d = S_MEM;
        else if (sel_we)           state_d = S_WB;
      end
      S_MEM: if (dm_ack) state_d = (ins_q[31:26] == OP_LW) ? S_WB : S_IDLE;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    dm_req   = (state_q == S_MEM);
    dm_we    = (state_q == S_MEM) && (ins_q[31:26] == OP_SW);
  end

  // Data registers are cleared on reset so the data outputs read 0 after RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ins_q      <= '0;
      alu_q      <= '0;
      npc_q      <= '0;
      sdata_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (accept) begin
        ins_q   <= Ins;
        alu_q   <= Alu;
        npc_q   <= NextPC;
        sdata_q <= Sdata;
      end
      rf_we_q <= (state_d == S_WB) && sel_we && (sel_waddr != 5'd0);
      if (state_d == S_WB) begin
        rf_waddr_q <= sel_waddr;
        rf_wdata_q <= sel_wdata;
      end
    end
  end

  assign dm_addr  = alu_q;
  assign dm_wdata = sdata_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level model of the stage.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Ins = '0, Alu = '0, NextPC = '0, Sdata = '0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  wb_stage dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .Ins(Ins), .Alu(Alu), .NextPC(NextPC), .Sdata(Sdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one instruction: memory class and the register write it should cause.
  typedef struct {
    bit          is_mem;
    bit          is_store;
    bit          writes;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } expect_t;

  function automatic expect_t model(input logic [31:0] ins, input logic [31:0] alu,
                                    input logic [31:0] npc, input logic [31:0] rdata);
    expect_t e;
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    e.is_mem   = (op == 'h23) || (op == 'h2B);
    e.is_store = (op == 'h2B);
    e.writes   = 1'b0;
    e.waddr    = ins[20:16];
    e.wdata    = alu;
    if (op == 0) begin
      e.writes = (fn != 'h08);
      e.waddr  = ins[15:11];
      if (fn == 'h09) e.wdata = npc;
    end else if (op == 'h03) begin
      e.writes = 1'b1;
      e.waddr  = 5'd31;
      e.wdata  = npc;
    end else if (op inside {'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F}) begin
      e.writes = 1'b1;
    end else if (op == 'h23) begin
      e.writes = 1'b1;
      e.wdata  = rdata;
    end
    return e;
  endfunction

  // One transaction from an idle stage; ack_dly idle MEM cycles precede the ack cycle.
  task automatic do_op(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] npc,
                       input logic [31:0] sdata, input int ack_dly, input logic [31:0] rdata,
                       input bit noise);
    expect_t e;
    e = model(ins, alu, npc, rdata);
    @(negedge CLK);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; Ins = ins; Alu = alu; NextPC = npc; Sdata = sdata;
    @(negedge CLK);
    if (noise && (e.is_mem || e.writes)) begin
      in_valid = 1'b1; Ins = $urandom; Alu = $urandom; NextPC = $urandom; Sdata = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    if (e.is_mem) begin
      for (int c = 0; c <= ack_dly; c++) begin
        check("mem_req",   {31'd0, dm_req},   32'd1);
        check("mem_we",    {31'd0, dm_we},    {31'd0, e.is_store});
        check("mem_addr",  dm_addr,  alu);
        check("mem_wdata", dm_wdata, sdata);
        check("mem_ready", {31'd0, in_ready}, 32'd0);
        check("mem_rfwe",  {31'd0, rf_we},    32'd0);
        dm_ack   = (c == ack_dly);
        dm_rdata = (c == ack_dly) ? rdata : $urandom;
        @(negedge CLK);
      end
      dm_ack = 1'b0;
      check("post_req", {31'd0, dm_req}, 32'd0);
    end
    if (e.writes) begin
      check("wb_we",    {31'd0, rf_we}, {31'd0, (e.waddr != 5'd0)});
      check("wb_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
      check("wb_wdata", rf_wdata, e.wdata);
      check("wb_busy",  {31'd0, busy}, 32'd1);
      @(negedge CLK);
      in_valid = 1'b0;
    end
    check("end_ready", {31'd0, in_ready}, 32'd1);
    check("end_busy",  {31'd0, busy},     32'd0);
    check("end_rfwe",  {31'd0, rf_we},    32'd0);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [16];
    logic [5:0] fns [5];
    logic [31:0] r;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
            6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h0B};
    fns = '{6'h08, 6'h09, 6'h20, 6'h21, 6'h2A};
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r[31:26] = 6'($urandom_range(0, 63));
    else                           r[31:26] = ops[$urandom_range(0, 15)];
    if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 4)];
    if ($urandom_range(0, 7) == 0) begin
      r[20:16] = 5'd0;
      r[15:11] = 5'd0;
    end
    return r;
  endfunction

  initial begin
    #2;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_req",   {31'd0, dm_req},   32'd0);
    check("rst_dmwe",  {31'd0, dm_we},    32'd0);
    check("rst_rfwe",  {31'd0, rf_we},    32'd0);
    check("rst_addr",  dm_addr,  32'd0);
    check("rst_rfdat", rf_wdata, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // ADD $t1,$t2,$t3
    do_op({6'h00, 5'd10, 5'd11, 5'd9, 5'd0, 6'h20}, 32'h11, 32'h104, 32'h0, 0, 32'h0, 1'b0);
    // LW $t0,4($s7), ack on third MEM cycle
    do_op({6'h23, 5'd23, 5'd8, 16'd4}, 32'h1B, 32'h200, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    // SW with same-cycle ack
    do_op({6'h2B, 5'd23, 5'd8, 16'd0}, 32'h20, 32'h204, 32'h55, 0, 32'h0, 1'b0);
    // JAL, JALR rd=5, BEQ
    do_op({6'h03, 26'h0000100}, 32'h0, 32'h404, 32'h0, 0, 32'h0, 1'b0);
    do_op({6'h00, 5'd31, 5'd0, 5'd5, 5'd0, 6'h09}, 32'h77, 32'h108, 32'h0, 0, 32'h0, 1'b0);
    do_op({6'h04, 5'd1, 5'd2, 16'hFFFC}, 32'h9, 32'h10C, 32'h0, 0, 32'h0, 1'b0);
    // ADDI to $zero; LW with in_valid noise during MEM
    do_op({6'h08, 5'd3, 5'd0, 16'h7}, 32'h7, 32'h110, 32'h0, 0, 32'h0, 1'b0);
    do_op({6'h23, 5'd4, 5'd12, 16'h8}, 32'h40, 32'h114, 32'h0, 3, 32'h12345678, 1'b1);

    // Reset while waiting in MEM, then a late ack must be ignored
    @(negedge CLK);
    in_valid = 1'b1; Ins = {6'h23, 5'd4, 5'd13, 16'h0}; Alu = 32'h80;
    @(negedge CLK);
    in_valid = 1'b0;
    check("pre_rst_req", {31'd0, dm_req}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_req",   {31'd0, dm_req},   32'd0);
    check("rst_mid_busy",  {31'd0, busy},     32'd0);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(negedge CLK);
    dm_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("late_ack_rfwe", {31'd0, rf_we}, 32'd0);
      check("late_ack_busy", {31'd0, busy},  32'd0);
      @(negedge CLK);
    end

    for (int i = 0; i < 300; i++) begin
      do_op(rand_ins(), $urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom,
            bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
